exec_csr: RTL

EXEC_CSR -- requirements
Module: exec_csr

---
 rtl/exec_csr_pkg.sv | 36 +++
 rtl/csr_counter.sv | 30 +++
 rtl/exec_csr.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/exec_csr_pkg.sv
// Shared constants for the machine-mode CSR block: privilege encodings, trap causes,
// CSR addresses and the funct3 operation encoding.
package priv_levels;
    localparam logic [1:0] PRIV_USER       = 2'b00;
    localparam logic [1:0] PRIV_SUPERVISOR = 2'b01;
    localparam logic [1:0] PRIV_MACHINE    = 2'b11;
endpackage

package trap_causes;
    localparam logic [3:0] EXC_ILLEGAL_INSTR = 4'd2;
endpackage

package csr_addrs;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    // funct3[1:0]; funct3[2] only selects register vs. immediate operand
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;
endpackage

// File: rtl/csr_counter.sv
// 64-bit CSR counter with a software load port; a load takes priority over the increment.
module csr_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en_i,
    input  logic [63:0] load_val_i,
    input  logic        inc_en_i,
    output logic [63:0] count_o
);
    logic [63:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_en_i) begin
            count_d = load_val_i;
        end else if (inc_en_i) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/exec_csr.sv
// Machine-mode CSR file: combinational read/decode with next-edge commit, trap entry,
// MRET return and the mcycle/minstret counters.
module exec_csr
    import priv_levels::*;
    import trap_causes::*;
    import csr_addrs::*;
#(
    parameter int unsigned     XLEN    = 64,
    parameter int unsigned     ALEN    = 64,
    parameter logic [XLEN-1:0] HART_ID = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exec_csr_instr_valid,
    input  logic [11:0]     exec_csr_addr,
    input  logic [2:0]      exec_csr_funct3,
    input  logic [4:0]      exec_csr_rd,
    input  logic [4:0]      exec_csr_rs1_uimm,
    input  logic [XLEN-1:0] exec_csr_rs1_data,
    output logic            exec_csr_exception,
    output logic [3:0]      exec_csr_trap_cause,
    output logic [XLEN-1:0] exec_csr_result,
    input  logic            trap_valid,
    input  logic [3:0]      trap_cause,
    input  logic            trap_is_interrupt,
    input  logic [ALEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            xret_valid,
    input  logic            instr_retired,
    input  logic            irq_timer,
    input  logic            irq_external,
    output logic [1:0]      privilege_mode,
    output logic [XLEN-1:0] mstatus,
    output logic [XLEN-1:0] mtvec,
    output logic [ALEN-1:0] mepc,
    output logic            interrupt_pending
);
    // RV64I: MXL=2 in the top two bits, extension bit 8 ('I')
    localparam logic [XLEN-1:0] MISA_VAL = {2'b10, {(XLEN-28){1'b0}}, 26'h100};

    logic [1:0]      priv_q, priv_d;
    logic            st_mie_q, st_mie_d;
    logic            st_mpie_q, st_mpie_d;
    logic [1:0]      st_mpp_q, st_mpp_d;
    logic            mie_mtie_q, mie_mtie_d;
    logic            mie_meie_q, mie_meie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [ALEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [63:0]     mcycle_cnt, minstret_cnt;

    logic [XLEN-1:0] mstatus_rd, mie_rd, mip_rd;
    logic [XLEN-1:0] csr_rdata, csr_wdata, csr_operand;
    logic            csr_impl, wr_attempt, illegal, csr_wr_en;
    csr_op_e         csr_op;
    logic            unused_rd;

    assign unused_rd = ^exec_csr_rd;

    always_comb begin
        mstatus_rd         = '0;
        mstatus_rd[3]      = st_mie_q;
        mstatus_rd[7]      = st_mpie_q;
        mstatus_rd[12:11]  = st_mpp_q;
        mie_rd             = '0;
        mie_rd[7]          = mie_mtie_q;
        mie_rd[11]         = mie_meie_q;
        mip_rd             = '0;
        mip_rd[7]          = irq_timer;
        mip_rd[11]         = irq_external;
    end

    always_comb begin
        csr_rdata = '0;
        csr_impl  = 1'b1;
        case (exec_csr_addr)
            CSR_MSTATUS:              csr_rdata = mstatus_rd;
            CSR_MISA:                 csr_rdata = MISA_VAL;
            CSR_MIE:                  csr_rdata = mie_rd;
            CSR_MTVEC:                csr_rdata = mtvec_q;
            CSR_MSCRATCH:             csr_rdata = mscratch_q;
            CSR_MEPC:                 csr_rdata = XLEN'(mepc_q);
            CSR_MCAUSE:               csr_rdata = mcause_q;
            CSR_MTVAL:                csr_rdata = mtval_q;
            CSR_MIP:                  csr_rdata = mip_rd;
            CSR_MCYCLE, CSR_CYCLE:    csr_rdata = XLEN'(mcycle_cnt);
            CSR_MINSTRET, CSR_INSTRET: csr_rdata = XLEN'(minstret_cnt);
            CSR_MHARTID:              csr_rdata = HART_ID;
            default:                  csr_impl  = 1'b0;
        endcase
    end

    assign csr_op      = csr_op_e'(exec_csr_funct3[1:0]);
    assign wr_attempt  = (csr_op == CSR_OP_RW) || (exec_csr_rs1_uimm != 5'd0);
    assign csr_operand = exec_csr_funct3[2] ? XLEN'(exec_csr_rs1_uimm) : exec_csr_rs1_data;

    always_comb begin
        case (csr_op)
            CSR_OP_RW: csr_wdata = csr_operand;
            CSR_OP_RS: csr_wdata = csr_rdata | csr_operand;
            CSR_OP_RC: csr_wdata = csr_rdata & ~csr_operand;
            default:   csr_wdata = csr_rdata;
        endcase
    end

    assign illegal = !csr_impl
                  || (exec_csr_addr[9:8] > priv_q)
                  || ((exec_csr_addr[11:10] == 2'b11) && wr_attempt)
                  || (csr_op == CSR_OP_NONE);

    assign exec_csr_exception  = exec_csr_instr_valid && illegal;
    assign exec_csr_trap_cause = EXC_ILLEGAL_INSTR;
    assign exec_csr_result     = csr_rdata;
    // Trap and MRET both preempt the software write in the same cycle
    assign csr_wr_en = exec_csr_instr_valid && !illegal && wr_attempt && !trap_valid && !xret_valid;

    always_comb begin
        priv_d     = priv_q;
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        st_mpp_d   = st_mpp_q;
        mie_mtie_d = mie_mtie_q;
        mie_meie_d = mie_meie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (trap_valid) begin
            mepc_d          = trap_pc & ~ALEN'(3);
            mcause_d        = '0;
            mcause_d[XLEN-1] = trap_is_interrupt;
            mcause_d[3:0]   = trap_cause;
            mtval_d         = trap_tval;
            st_mpie_d       = st_mie_q;
            st_mie_d        = 1'b0;
            st_mpp_d        = priv_q;
            priv_d          = PRIV_MACHINE;
        end else if (xret_valid) begin
            priv_d    = st_mpp_q;
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
            st_mpp_d  = PRIV_USER;
        end else if (csr_wr_en) begin
            case (exec_csr_addr)
                CSR_MSTATUS: begin
                    st_mie_d  = csr_wdata[3];
                    st_mpie_d = csr_wdata[7];
                    // 2'b10 is reserved; leave MPP unchanged
                    if (csr_wdata[12:11] != 2'b10) st_mpp_d = csr_wdata[12:11];
                end
                CSR_MIE: begin
                    mie_mtie_d = csr_wdata[7];
                    mie_meie_d = csr_wdata[11];
                end
                CSR_MTVEC:    mtvec_d    = csr_wdata & ~XLEN'(3);
                CSR_MSCRATCH: mscratch_d = csr_wdata;
                CSR_MEPC:     mepc_d     = ALEN'(csr_wdata) & ~ALEN'(3);
                CSR_MCAUSE:   mcause_d   = csr_wdata;
                CSR_MTVAL:    mtval_d    = csr_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            priv_q     <= PRIV_MACHINE;
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            st_mpp_q   <= 2'b00;
            mie_mtie_q <= 1'b0;
            mie_meie_q <= 1'b0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            priv_q     <= priv_d;
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            st_mpp_q   <= st_mpp_d;
            mie_mtie_q <= mie_mtie_d;
            mie_meie_q <= mie_meie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

    csr_counter u_mcycle (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en_i  (csr_wr_en && (exec_csr_addr == CSR_MCYCLE)),
        .load_val_i (64'(csr_wdata)),
        .inc_en_i   (1'b1),
        .count_o    (mcycle_cnt)
    );

    csr_counter u_minstret (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en_i  (csr_wr_en && (exec_csr_addr == CSR_MINSTRET)),
        .load_val_i (64'(csr_wdata)),
        .inc_en_i   (instr_retired),
        .count_o    (minstret_cnt)
    );

    assign privilege_mode    = priv_q;
    assign mstatus           = mstatus_rd;
    assign mtvec             = mtvec_q;
    assign mepc              = mepc_q;
    assign interrupt_pending = (|(mie_rd & mip_rd)) && (st_mie_q || (priv_q != PRIV_MACHINE));
endmodule
